// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Loads a length-prefixed program image from an 8-bit valid/ready byte
// stream into instruction memory, holding the core in reset until the image
// is complete, then releases it.
//
// Stream: N[7:0], N[15:8], then 4*N data bytes (each word LSB first),
// then one XOR checksum byte when BOOT_CHECKSUM_EN is defined.
//
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte).
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is registered; a byte offered while rx_ready is low is ignored
// and the producer must keep offering it.
//
// Ports:
//   clk           clock, rising edge
//   global_reset  synchronous active-high reset
//   rx_data       stream byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte this cycle
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     word address of the write (holds between strobes)
//   imem_wdata    assembled word {b3,b2,b1,b0} (holds between strobes)
//   core_reset    high while the core is held in reset
//   busy          load in progress
//   done          image loaded, core running
//   err           sticky load error
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_q;
  logic              rx_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [15:0]       cnt_q;       // word count N from the header
  logic [ADDR_W-1:0] widx_q;      // index of the word being assembled
  logic [1:0]        lane_q;      // byte lane within the current word
  logic [23:0]       byte_buf_q;  // lanes 0..2 of the current word
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q;       // running XOR over data bytes
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic        hdr_bad;
  logic        last_word;

  assign xfer  = rx_valid && rx_ready_q;
  assign hdr_n = {rx_data, cnt_q[7:0]};
  // N == 2^ADDR_W is legal, hence the 32-bit comparison
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > (32'd1 << ADDR_W));
  assign last_word = ((32'(widx_q) + 32'd1) == 32'(cnt_q));

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q      <= S_HDR0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      widx_q       <= '0;
      lane_q       <= '0;
      byte_buf_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      // Release is derived from the registered state, giving the extra
      // cycle between the final write strobe and the core starting.
      done_q       <= (state_q == S_RUN);
      core_reset_q <= (state_q != S_RUN);
      if (state_q == S_RUN) busy_q <= 1'b0;

      case (state_q)
        S_HDR0: begin
          rx_ready_q <= 1'b1;
          if (xfer) begin
            cnt_q[7:0] <= rx_data;
            busy_q     <= 1'b1;
            state_q    <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (xfer) begin
            cnt_q[15:8] <= rx_data;
            if (hdr_bad) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              rx_ready_q <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            lane_q <= lane_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            xor_q  <= xor_q ^ rx_data;
`endif
            case (lane_q)
              2'd0: byte_buf_q[7:0]   <= rx_data;
              2'd1: byte_buf_q[15:8]  <= rx_data;
              2'd2: byte_buf_q[23:16] <= rx_data;
              default: begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= widx_q;
                imem_wdata_q <= {rx_data, byte_buf_q};
                widx_q       <= widx_q + ADDR_W'(1);
                if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                  state_q    <= S_CHK;
`else
                  state_q    <= S_RUN;
                  rx_ready_q <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef BOOT_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            rx_ready_q <= 1'b0;
            if (rx_data == xor_q) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
`endif

        default: begin
          // RUN and ERR are terminal until reset
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: builds images from word lists, streams
// them (optionally with valid gaps), and compares observed memory writes
// and release timing against an expected write queue.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;
  localparam int WW     = ADDR_W + 32;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              global_reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] obs_q[$];
  logic [31:0]   img[$];

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .global_reset(global_reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .err(err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // write monitor
  always @(negedge clk) begin
    if (imem_we === 1'b1) obs_q.push_back({imem_addr, imem_wdata});
  end

  // driver tasks
  task automatic assert_reset();
    @(negedge clk);
    global_reset = 1'b1;
    rx_valid     = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    global_reset = 1'b0;
    @(negedge clk);
    obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int idle;
    int waited;
    idle = gaps ? $urandom_range(0, 2) : 0;
    @(negedge clk);
    for (int i = 0; i < idle; i++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic check_scoreboard(input string name);
    logic [WW-1:0] e, o;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s_write: got addr=%h data=%h, required addr=%h data=%h",
                 name, o[WW-1:32], o[31:0], e[WW-1:32], e[31:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Streams img[] (already reset), checks release timing and the writes.
  task automatic load_image(input string name, input bit gaps, input bit bad_sum);
    int n;
    logic [7:0] b;
    logic [7:0] sum;
    bit good;
    n    = img.size();
    sum  = 8'h00;
    good = !(CHK_EN && bad_sum);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), img[i]});
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b   = 8'(img[i] >> (8 * k));
        sum = sum ^ b;
        send_byte(b, gaps);
      end
    end
    if (CHK_EN) send_byte(bad_sum ? (sum ^ 8'h01) : sum, gaps);
    // cycle E+1
    @(negedge clk);
    rx_valid = 1'b0;
    n_checks++;
    if (rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_ready_drop: rx_ready=%b required 0", name, rx_ready);
    end
    n_checks++;
    if (imem_we !== !CHK_EN) begin
      n_fail++; $display("FAIL %s_last_we: imem_we=%b required %b", name, imem_we, !CHK_EN);
    end
    n_checks++;
    if (done !== 1'b0 || core_reset !== 1'b1) begin
      n_fail++; $display("FAIL %s_early_release: done=%b core_reset=%b required 0/1", name, done, core_reset);
    end
    // cycle E+2
    @(negedge clk);
    n_checks++;
    if (done !== good || core_reset !== !good || err !== !good || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: done=%b core_reset=%b err=%b busy=%b required %b/%b/%b/0",
               name, done, core_reset, err, busy, good, !good, !good);
    end
    repeat (2) @(negedge clk);
    check_scoreboard(name);
  endtask

  // scenario tasks
  task automatic check_reset_values(input string name);
    n_checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, err} !==
        {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_reset_values: rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b required 0 0 0 0 1 0 0 0",
               name, rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, err);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    check_reset_values("reset");
    release_reset();
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic set_spec_image();
    img.delete();
    img.push_back(32'h00100513);
    img.push_back(32'h00200593);
  endtask

  task automatic test_spec_stream();
    assert_reset(); release_reset();
    set_spec_image();
    load_image("spec", 1'b0, 1'b0);
    assert_reset(); release_reset();
    set_spec_image();
    load_image("spec_gaps", 1'b1, 1'b0);
  endtask

  task automatic test_after_done();
    assert_reset(); release_reset();
    set_spec_image();
    load_image("pre_idle", 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      n_checks++;
      if (rx_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_after_done: rx_ready=%b imem_we=%b done=%b required 0/0/1", rx_ready, imem_we, done);
      end
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check_scoreboard("idle_after_done");
  endtask

  task automatic test_hdr_err(input logic [7:0] lo, input logic [7:0] hi);
    string name;
    name = $sformatf("hdr_err_%h%h", hi, lo);
    assert_reset(); release_reset();
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || rx_ready !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: err=%b rx_ready=%b core_reset=%b busy=%b done=%b required 1/0/1/0/0",
               name, err, rx_ready, core_reset, busy, done);
    end
    rx_valid = 1'b1;
    repeat (8) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL %s_sticky: err=%b required 1", name, err);
    end
    exp_q.delete();
    check_scoreboard(name);
  endtask

  task automatic test_midload_reset();
    logic [7:0] bytes[7];
    bytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
    assert_reset(); release_reset();
    for (int i = 0; i < 7; i++) send_byte(bytes[i], 1'b0);
    exp_q.delete();
    exp_q.push_back({ADDR_W'(0), 32'h00100513});
    assert_reset();
    check_reset_values("midload");
    check_scoreboard("midload_partial");
    release_reset();
    img.delete();
    img.push_back(32'hDEADBEEF);
    load_image("after_midload", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    bit gaps, bad;
    for (int t = 0; t < 6; t++) begin
      n    = $urandom_range(1, 12);
      gaps = 1'($urandom_range(0, 1));
      bad  = CHK_EN && ($urandom_range(0, 1) == 1);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      assert_reset(); release_reset();
      load_image($sformatf("random%0d", t), gaps, bad);
    end
  endtask

  task automatic test_full_capacity();
    img.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) img.push_back($urandom);
    assert_reset(); release_reset();
    load_image("full_capacity", 1'b0, 1'b0);
  endtask

  task automatic test_checksum();
`ifdef BOOT_CHECKSUM_EN
    assert_reset(); release_reset();
    set_spec_image();
    load_image("chk_good", 1'b0, 1'b0);
    assert_reset(); release_reset();
    set_spec_image();
    load_image("chk_bad", 1'b0, 1'b1);
`endif
  endtask

  initial begin
    test_reset();
    test_spec_stream();
    test_hdr_err(8'h00, 8'h00);
    test_hdr_err(8'h01, 8'h01);
    test_midload_reset();
    test_checksum();
    test_after_done();
    test_random();
    test_full_capacity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader sitting directly upstream of the pipelined core's fetch stage. It receives a length-prefixed program image over an 8-bit valid/ready stream and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory from word address 0, holding the core in reset throughout. After the image is loaded (and optionally checksum-verified), it releases the core's reset line.

## Interface
Parameters:
- ADDR_W, default 8: instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- global_reset  input  1  synchronous, active-high reset.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte; transfer = rx_valid && rx_ready on a rising edge.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address of the current write.
- imem_wdata  output  32  assembled instruction word.
- core_reset  output  1  drives the core's reset input; high = core held in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded, core running.
- err  output  1  sticky load error.

## Operation
- Stream format: count low byte, count high byte (N, 16-bit word count), then 4N data bytes, each word LSB first. With BOOT_CHECKSUM_EN, one checksum byte follows.
- States and transitions:
  - HDR0: accepts the count low byte, then goes to HDR1.
  - HDR1: accepts the count high byte. If N == 0 or N > 2^ADDR_W, go to ERR; otherwise go to DATA.
  - DATA: accepts bytes into byte lane k = byte index mod 4. On the 4th byte of a word, write the word. After the last word, go to CHK (macro defined) or RUN.
  - CHK: accepts one checksum byte. If it matches, go to RUN; otherwise go to ERR.
  - RUN: terminal until reset.
  - ERR: terminal until reset.
- rx_ready = 1 in HDR0, HDR1, DATA and CHK; 0 in RUN, ERR and during reset.
- Bytes presented while rx_ready = 0 are ignored and cause no state change.
- Word write: imem_addr = word index (0 .. N-1); imem_wdata = {b3,b2,b1,b0}. The word index increments after each write. imem_addr and imem_wdata hold their last values between strobes.
- busy = 1 from acceptance of the count low byte until RUN or ERR is entered.
- done = 1 only in RUN.
- err = 1 only in ERR.
- core_reset = 0 only in RUN.
- global_reset asserted mid-load returns the block to HDR0 with the word index cleared and core_reset = 1. Memory contents already written are not erased.

## Timing
- All outputs are registered.
- Reset values: rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, busy 0, done 0, err 0.
- rx_ready rises in the first cycle after global_reset deasserts.
- Throughput: one byte per cycle with rx_valid held high. Gaps in rx_valid are tolerated; no byte is lost or duplicated.
- Write latency: the 4th byte of a word is accepted at edge E; imem_we is high for exactly the cycle after E.
- Release without the macro: the last data byte is accepted at edge E. imem_we is high in cycle E+1; core_reset and busy fall and done rises in cycle E+2.
- Release with the macro: the checksum byte is accepted at edge E; core_reset falls in cycle E+2.
- rx_ready drops in the cycle after the final accepted byte.
- ERR from header: err rises in the cycle after the count high byte is accepted. No imem_we is ever issued.
- N = 2^ADDR_W is legal. The final write goes to address 2^ADDR_W - 1 with no wrap.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - CHK state is present.
  - A running 8-bit XOR is kept over all 4N data bytes; header bytes are excluded.
  - The trailing byte must equal the XOR, otherwise ERR. The core stays in reset even though the words were already written.
- BOOT_CHECKSUM_EN undefined:
  - No CHK state and no trailing byte.
  - RUN is entered directly after the last data word.

## Test plan
- Stream 02 00 13 05 10 00 93 05 20 00 → writes addr 0 = 0x00100513 and addr 1 = 0x00200593, one-cycle strobes. core_reset = 0 and done = 1 two cycles after the last byte.
- Same stream with rx_valid toggling every other cycle → identical two writes, no extra strobes, same final state.
- Header 00 00 → err = 1, rx_ready = 0, no imem_we, core_reset stays 1. Repeat with header 01 01 (N = 257, ADDR_W = 8) → same result.
- Assert global_reset after 5 data bytes of the first stream → outputs at reset values. A fresh stream 01 00 EF BE AD DE then writes addr 0 = 0xDEADBEEF.
- With BOOT_CHECKSUM_EN: the first stream plus B0 → RUN. The same stream plus B1 → err = 1 and core_reset = 1, although both words were written.
- After done, hold rx_valid = 1 with arbitrary bytes for 20 cycles → rx_ready = 0, no imem_we, done stays 1.
